// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM, IF/ID pipeline register.
// Ports: clk/rst, JumpTaken/JumpPC, BranchTaken/BranchPC, Stall,
//   IMemReady/IMemData in; IMemReq/IMemAddr, IFIDPCPlus4/IFIDInstruction/IFIDValid out.
// Option: define FETCH_STATS_EN to add FetchCount/BubbleCount outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        JumpTaken,
  input  logic [31:0] JumpPC,
  input  logic        BranchTaken,
  input  logic [31:0] BranchPC,
  input  logic        Stall,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] IFIDPCPlus4,
  output logic [31:0] IFIDInstruction,
  output logic        IFIDValid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] tgt;
  logic        req;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] load_word;
  logic        load_valid;

  assign redirect  = JumpTaken | BranchTaken;
  assign target    = JumpTaken ? JumpPC : BranchPC;
  assign pc_plus4  = pc + 32'd4;
  assign load_word = (state == S_HOLD) ? hold_buf : IMemData;
  assign IMemAddr  = pc;
  assign IMemReq   = req;

  // A word enters IF/ID only when neither a redirect nor a stall blocks it.
  always_comb begin
    load_valid = 1'b0;
    if (!redirect && !Stall) begin
      unique case (state)
        S_FETCH, S_WAIT: load_valid = IMemReady;
        S_HOLD:          load_valid = 1'b1;
        default:         load_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_FETCH;
      pc              <= RESET_PC;
      hold_buf        <= 32'h0;
      tgt             <= 32'h0;
      req             <= 1'b1;
      IFIDPCPlus4     <= 32'h0;
      IFIDInstruction <= 32'h0;
      IFIDValid       <= 1'b0;
    end else begin
      req <= 1'b1;

      // IF/ID: flush on redirect, load, bubble, or hold under stall.
      if (redirect) begin
        IFIDValid       <= 1'b0;
        IFIDInstruction <= 32'h0;
      end else if (load_valid) begin
        IFIDPCPlus4     <= pc_plus4;
        IFIDInstruction <= load_word;
        IFIDValid       <= 1'b1;
      end else if (!Stall) begin
        IFIDValid       <= 1'b0;
        IFIDInstruction <= 32'h0;
      end

      unique case (state)
        S_FETCH: begin
          if (redirect) begin
            if (IMemReady) begin
              pc <= target;
            end else begin
              tgt   <= target;
              state <= S_DROP;
            end
          end else if (!IMemReady) begin
            state <= S_WAIT;
          end else if (!Stall) begin
            pc <= pc_plus4;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            if (IMemReady) begin
              pc    <= target;
              state <= S_FETCH;
            end else begin
              tgt   <= target;
              state <= S_DROP;
            end
          end else if (IMemReady) begin
            if (Stall) begin
              hold_buf <= IMemData;
              state    <= S_HOLD;
              req      <= 1'b0;
            end else begin
              pc    <= pc_plus4;
              state <= S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_FETCH;
          end else if (Stall) begin
            req <= 1'b0;
          end else begin
            pc    <= pc_plus4;
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          // The outstanding word belongs to the old path; wait it out.
          if (redirect) begin
            if (IMemReady) begin
              pc    <= target;
              state <= S_FETCH;
            end else begin
              tgt <= target;
            end
          end else if (IMemReady) begin
            pc    <= tgt;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount  <= 32'h0;
      BubbleCount <= 32'h0;
    end else if (load_valid) begin
      FetchCount  <= FetchCount + 32'd1;
    end else begin
      BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard on IF/ID loads.
// Stimulus pushes expected {PC+4, word}; a monitor pops on each new load.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        JumpTaken;
  logic [31:0] JumpPC;
  logic        BranchTaken;
  logic [31:0] BranchPC;
  logic        Stall;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IFIDPCPlus4;
  logic [31:0] IFIDInstruction;
  logic        IFIDValid;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] sb[$];
  bit          done = 1'b0;

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .JumpTaken(JumpTaken),
    .JumpPC(JumpPC),
    .BranchTaken(BranchTaken),
    .BranchPC(BranchPC),
    .Stall(Stall),
    .IMemReady(IMemReady),
    .IMemData(IMemData),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IFIDPCPlus4(IFIDPCPlus4),
    .IFIDInstruction(IFIDInstruction),
    .IFIDValid(IFIDValid)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount(FetchCount),
    .BubbleCount(BubbleCount)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns addr ^ DEAD0000 when ready, junk otherwise.
  assign IMemData = IMemReady ? (IMemAddr ^ 32'hDEAD_0000) : 32'hBADB_AD00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] ins);
    sb.push_back({pc4, ins});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: after an edge with Stall=0 and rst=0, IFIDValid=1 means a load.
  initial begin
    logic s, r;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      s = Stall;
      r = rst;
      #2;
      if (!done && !r && !s && IFIDValid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h_%h expected none",
                   IFIDPCPlus4, IFIDInstruction);
        end else begin
          e = sb.pop_front();
          if ({IFIDPCPlus4, IFIDInstruction} !== e) begin
            errors++;
            $display("FAIL sb_load: got %h_%h expected %h_%h",
                     IFIDPCPlus4, IFIDInstruction, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; JumpTaken = 1'b0; JumpPC = 32'h0;
    BranchTaken = 1'b0; BranchPC = 32'h0;
    Stall = 1'b0; IMemReady = 1'b0;
    step;
    step;
    chk("rst_addr", IMemAddr, 32'h3000);
    chk("rst_valid", {31'h0, IFIDValid}, 32'h0);
    chk("rst_instr", IFIDInstruction, 32'h0);
    chk("rst_pc4", IFIDPCPlus4, 32'h0);
    chk("rst_req", {31'h0, IMemReq}, 32'h1);

    // Back-to-back fetch
    rst = 1'b0; IMemReady = 1'b1;
    push(32'h3004, 32'hDEAD_3000);
    step;
    chk("seq_addr1", IMemAddr, 32'h3004);
    push(32'h3008, 32'hDEAD_3004);
    step;
    chk("seq_addr2", IMemAddr, 32'h3008);
    chk("seq_valid", {31'h0, IFIDValid}, 32'h1);

    // Memory wait
    IMemReady = 1'b0;
    step;
    chk("wait_addr1", IMemAddr, 32'h3008);
    step;
    chk("wait_addr2", IMemAddr, 32'h3008);
    chk("wait_req", {31'h0, IMemReq}, 32'h1);
    IMemReady = 1'b1;
    push(32'h300C, 32'hDEAD_3008);
    step;
    chk("wait_done_addr", IMemAddr, 32'h300C);

    // Stall when ready arrives in WAIT
    IMemReady = 1'b0;
    step;
    IMemReady = 1'b1; Stall = 1'b1;
    step;
    chk("hold_req1", {31'h0, IMemReq}, 32'h0);
    IMemReady = 1'b0;
    step;
    chk("hold_req2", {31'h0, IMemReq}, 32'h0);
    chk("hold_addr", IMemAddr, 32'h300C);
    step;
    chk("hold_valid", {31'h0, IFIDValid}, 32'h0);
    Stall = 1'b0;
    push(32'h3010, 32'hDEAD_300C);
    step;
    chk("hold_rel_addr", IMemAddr, 32'h3010);
    chk("hold_rel_req", {31'h0, IMemReq}, 32'h1);

    // Stall in FETCH with ready: IF/ID and PC held
    IMemReady = 1'b1; Stall = 1'b1;
    step;
    chk("fstall_addr", IMemAddr, 32'h3010);
    chk("fstall_instr", IFIDInstruction, 32'hDEAD_300C);
    chk("fstall_valid", {31'h0, IFIDValid}, 32'h1);

    // Jump and branch together under stall: jump wins, flush
    JumpTaken = 1'b1; JumpPC = 32'h0040_0000;
    BranchTaken = 1'b1; BranchPC = 32'h0000_3100;
    step;
    chk("jmp_addr", IMemAddr, 32'h0040_0000);
    chk("jmp_valid", {31'h0, IFIDValid}, 32'h0);
    chk("jmp_instr", IFIDInstruction, 32'h0);
    chk("jmp_pc4", IFIDPCPlus4, 32'h3010);
    JumpTaken = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    push(32'h0040_0004, 32'hDEED_0000);
    step;
    chk("jmp_next", IMemAddr, 32'h0040_0004);

    // Branch during WAIT, word dropped
    IMemReady = 1'b0;
    step;
    BranchTaken = 1'b1; BranchPC = 32'h3100;
    step;
    chk("drop_addr", IMemAddr, 32'h0040_0004);
    BranchTaken = 1'b0;
    step;
    IMemReady = 1'b1;
    step;
    chk("drop_tgt", IMemAddr, 32'h3100);
    chk("drop_valid", {31'h0, IFIDValid}, 32'h0);
    push(32'h3104, 32'hDEAD_3100);
    step;

    // PC wrap
    JumpTaken = 1'b1; JumpPC = 32'hFFFF_FFFC;
    step;
    chk("wrap_jmp", IMemAddr, 32'hFFFF_FFFC);
    JumpTaken = 1'b0;
    push(32'h0, 32'h2152_FFFC);
    step;
    chk("wrap_addr", IMemAddr, 32'h0);

    // Redirect in HOLD
    IMemReady = 1'b0;
    step;
    IMemReady = 1'b1; Stall = 1'b1;
    step;
    chk("hredir_req0", {31'h0, IMemReq}, 32'h0);
    BranchTaken = 1'b1; BranchPC = 32'h3200;
    step;
    chk("hredir_addr", IMemAddr, 32'h3200);
    chk("hredir_req", {31'h0, IMemReq}, 32'h1);
    chk("hredir_valid", {31'h0, IFIDValid}, 32'h0);
    BranchTaken = 1'b0; Stall = 1'b0;
    push(32'h3204, 32'hDEAD_3200);
    step;

    // New redirect in DROP overwrites latched target
    IMemReady = 1'b0;
    step;
    JumpTaken = 1'b1; JumpPC = 32'h5000;
    step;
    JumpTaken = 1'b0; BranchTaken = 1'b1; BranchPC = 32'h6000;
    step;
    chk("dropow_hold", IMemAddr, 32'h3204);
    BranchTaken = 1'b0; IMemReady = 1'b1;
    step;
    chk("dropow_addr", IMemAddr, 32'h6000);

    // Reset in DROP overrides everything
    IMemReady = 1'b0;
    step;
    BranchTaken = 1'b1; BranchPC = 32'h7000;
    step;
    rst = 1'b1; IMemReady = 1'b1; Stall = 1'b1;
    step;
    chk("rdrop_addr", IMemAddr, 32'h3000);
    chk("rdrop_valid", {31'h0, IFIDValid}, 32'h0);
    chk("rdrop_req", {31'h0, IMemReq}, 32'h1);
`ifdef FETCH_STATS_EN
    chk("rdrop_fcnt", FetchCount, 32'h0);
    chk("rdrop_bcnt", BubbleCount, 32'h0);
`endif
    rst = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    push(32'h3004, 32'hDEAD_3000);
    step;
    chk("post_rst_addr", IMemAddr, 32'h3004);
    Stall = 1'b1;
    step;
    step;
    done = 1'b1;
    chk("sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
